regfile_arbiter: RTL and testbench
==================================

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 SHALL provide: clk  in  1  single clock, rising edge; all state updates on it.
REQ-002 SHALL provide: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL provide core port: c_req_valid in 1; c_req_ready out 1; c_we in 1; c_rd in 5; c_r1 in 5; c_r2 in 5; c_wdata in 32.
REQ-004 SHALL provide core response: c_rsp_valid out 1; c_r1_data out 32; c_r2_data out 32.
REQ-005 SHALL provide debug port: d_req_valid in 1; d_req_ready out 1; d_we in 1; d_addr in 5; d_wdata in 32; d_rsp_valid out 1; d_rdata out 32.
REQ-006 SHALL provide regfile side: rf_rd, rf_r1, rf_r2 out 5; rf_write_data out 32; rf_w_en out 1; rf_r_en out 1; rf_r1_read, rf_r2_read in 32.
REQ-007 SHALL use parameter STARVE_LIMIT, default 4: max consecutive core grants while debug waits.

Function
REQ-008 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE; one transaction in flight at a time.
REQ-009 SHALL assert x_req_ready only in IDLE and only for the requester granted that cycle; acceptance = valid & ready.
REQ-010 SHALL grant core over debug, except debug wins when starve_cnt == STARVE_LIMIT and d_req_valid.
REQ-011 SHALL increment starve_cnt on each core grant while d_req_valid high, saturating at STARVE_LIMIT; clear on any debug grant or when d_req_valid low.
REQ-012 SHALL register the accepted request at edge N and drive rf_* from registers throughout cycle N+1 (ISSUE), rf_r_en=1, rf_w_en=x_we.
REQ-013 SHALL map debug request: rf_r1=d_addr, rf_r2=0, rf_rd=d_addr.
REQ-014 SHALL in RESP (cycle N+2) assert the owner's rsp_valid for exactly one cycle, passing rf_r1_read/rf_r2_read through (debug: d_rdata=rf_r1_read); no response backpressure.
REQ-015 SHALL return pre-write value when a transaction writes and reads the same register (regfile read/write same edge).
REQ-016 SHALL return 0 on reads of x0; writes to x0 are issued but have no effect.
REQ-017 SHALL give every transaction, write-only included, exactly one rsp_valid pulse (ack).
REQ-018 SHALL drive rf_w_en=0, rf_r_en=0 in IDLE and RESP; response data outputs hold last value outside RESP.
REQ-019 SHALL sustain throughput of one transaction per 3 cycles; latency accept-to-response 2 cycles.

Reset
REQ-020 SHALL on rst_n=0 at an edge: state=IDLE, starve_cnt=0, all ready/rsp_valid/rf_w_en/rf_r_en=0, rf address/data regs=0.
REQ-021 SHALL, if reset is sampled at the edge ending ISSUE, let the regfile commit that write (regfile has no reset) but deliver no response.
REQ-022 SHALL accept no request in the cycle rst_n is low.

Configuration
REQ-023 SHALL use macro RF_DBG_PORT_EN: defined -> debug port and starvation logic as above.
REQ-024 SHALL, without RF_DBG_PORT_EN, keep debug ports present but tie d_req_ready=0, d_rsp_valid=0, d_rdata=0, omit starve_cnt; core always granted.

Structure
REQ-025 SHALL place FSM state enum, STARVE_LIMIT default, and REG_ADDR_W=5/XLEN=32 constants in shared package rf_pkg.
REQ-026 SHALL implement grant logic (priority + starvation counter) as sub-module rf_grant; FSM and datapath in regfile_arbiter.

Verification
REQ-027 Core write x5=0xDEADBEEF, then core read r1=5,r2=0 -> c_rsp_valid 2 cycles after each accept; c_r1_data=0xDEADBEEF, c_r2_data=0.
REQ-028 Core write rd=0 value 0x1234, read r1=0 -> c_r1_data=0.
REQ-029 Core and debug valid continuously -> debug granted on 5th grant slot (after 4 core), starve_cnt cleared, pattern repeats.
REQ-030 Single transaction we=1, rd=r1=7, wdata=0x55, x7 previously 0x11 -> c_r1_data=0x11; next read x7 -> 0x55.
REQ-031 rst_n low in ISSUE of debug write x9=0xA5 -> no d_rsp_valid, outputs reset; subsequent read x9 -> 0xA5.
REQ-032 Build without RF_DBG_PORT_EN, d_req_valid=1 for 20 cycles -> d_req_ready stays 0, core unaffected.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and FSM state type for the register-file arbiter slice.
package rf_pkg;
    localparam int unsigned REG_ADDR_W       = 5;
    localparam int unsigned XLEN             = 32;
    localparam int unsigned DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;
endpackage

// File: rtl/rf_grant.sv
// Core-over-debug grant with a starvation counter; debug path exists only
// when RF_DBG_PORT_EN is defined, otherwise the core is always granted.
module rf_grant
    import rf_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic idle,
    input  logic c_valid,
    input  logic d_valid,
    output logic gnt_c,
    output logic gnt_d
);
`ifdef RF_DBG_PORT_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 2);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // A grant is also an acceptance: ready is only raised for a valid requester.
    always_comb begin
        gnt_c = 1'b0;
        gnt_d = 1'b0;
        if (idle && rst_n) begin
            if (d_valid && (starved || !c_valid)) gnt_d = 1'b1;
            else if (c_valid)                     gnt_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                    starve_cnt <= '0;
        else if (!d_valid || gnt_d)    starve_cnt <= '0;
        else if (gnt_c && !starved)    starve_cnt <= starve_cnt + 1'b1;
    end
`else
    localparam int unsigned unused_limit = STARVE_LIMIT;
    logic unused_grant;

    assign unused_grant = ^{clk, d_valid};
    assign gnt_c        = idle && rst_n && c_valid;
    assign gnt_d        = 1'b0;
`endif
endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates core and debug access to a 2R1W register file (IDLE->ISSUE->RESP).
// Debug port is functional only when RF_DBG_PORT_EN is defined.
module regfile_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c_req_valid,
    output logic        c_req_ready,
    input  logic        c_we,
    input  logic [4:0]  c_rd,
    input  logic [4:0]  c_r1,
    input  logic [4:0]  c_r2,
    input  logic [31:0] c_wdata,
    output logic        c_rsp_valid,
    output logic [31:0] c_r1_data,
    output logic [31:0] c_r2_data,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_we,
    input  logic [4:0]  d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rdata,
    output logic [4:0]  rf_rd,
    output logic [4:0]  rf_r1,
    output logic [4:0]  rf_r2,
    output logic [31:0] rf_write_data,
    output logic        rf_w_en,
    output logic        rf_r_en,
    input  logic [31:0] rf_r1_read,
    input  logic [31:0] rf_r2_read
);
    state_t                state, state_nxt;
    logic                  gnt_c, gnt_d, accept;
    logic                  owner_dbg, we_q, rsp_c, rsp_d;
    logic [REG_ADDR_W-1:0] rd_q, r1_q, r2_q;
    logic [XLEN-1:0]       wdata_q, rd1, rd2, d_rdata_q;

    rf_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
        .clk     (clk),
        .rst_n   (rst_n),
        .idle    (state == ST_IDLE),
        .c_valid (c_req_valid),
        .d_valid (d_req_valid),
        .gnt_c   (gnt_c),
        .gnt_d   (gnt_d)
    );

    assign accept        = gnt_c || gnt_d;
    assign c_req_ready   = gnt_c;
    assign c_rsp_valid   = rsp_c;
    assign rf_rd         = rd_q;
    assign rf_r1         = r1_q;
    assign rf_r2         = r2_q;
    assign rf_write_data = wdata_q;
    assign rd1           = (r1_q == '0) ? '0 : rf_r1_read;
    assign rd2           = (r2_q == '0) ? '0 : rf_r2_read;

`ifdef RF_DBG_PORT_EN
    assign d_req_ready = gnt_d;
    assign d_rsp_valid = rsp_d;
    assign d_rdata     = d_rdata_q;
`else
    logic unused_dbg;
    assign unused_dbg  = ^{rsp_d, d_rdata_q};
    assign d_req_ready = 1'b0;
    assign d_rsp_valid = 1'b0;
    assign d_rdata     = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rf_r_en   = 1'b0;
        rf_w_en   = 1'b0;
        rsp_c     = 1'b0;
        rsp_d     = 1'b0;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                rf_r_en   = 1'b1;
                rf_w_en   = we_q;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_c     = !owner_dbg;
                rsp_d     = owner_dbg;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read data is captured at the edge ending ISSUE, before the write lands,
    // so a same-register read-modify returns the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_dbg <= 1'b0;
            we_q      <= 1'b0;
            rd_q      <= '0;
            r1_q      <= '0;
            r2_q      <= '0;
            wdata_q   <= '0;
            c_r1_data <= '0;
            c_r2_data <= '0;
            d_rdata_q <= '0;
        end else begin
            if (accept) begin
                owner_dbg <= gnt_d;
                if (gnt_d) begin
                    we_q    <= d_we;
                    rd_q    <= d_addr;
                    r1_q    <= d_addr;
                    r2_q    <= '0;
                    wdata_q <= d_wdata;
                end else begin
                    we_q    <= c_we;
                    rd_q    <= c_rd;
                    r1_q    <= c_r1;
                    r2_q    <= c_r2;
                    wdata_q <= c_wdata;
                end
            end
            if (state == ST_ISSUE) begin
                if (owner_dbg) d_rdata_q <= rd1;
                else begin
                    c_r1_data <= rd1;
                    c_r2_data <= rd2;
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: models the attached register file and predicts
// responses from an architectural shadow of register contents.
module tb_regfile_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_req_valid, c_req_ready, c_we, c_rsp_valid;
    logic [4:0]  c_rd, c_r1, c_r2;
    logic [31:0] c_wdata, c_r1_data, c_r2_data;
    logic        d_req_valid, d_req_ready, d_we, d_rsp_valid;
    logic [4:0]  d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic [4:0]  rf_rd, rf_r1, rf_r2;
    logic [31:0] rf_write_data, rf_r1_read, rf_r2_read;
    logic        rf_w_en, rf_r_en;

    // Raw storage: x0 is stored like any other cell, the arbiter must mask it.
    logic [31:0] mem    [32] = '{default: '0};
    logic [31:0] ref_rf [32] = '{default: '0};
    int total = 0;
    int bad   = 0;

`ifdef RF_DBG_PORT_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    assign rf_r1_read = mem[rf_r1];
    assign rf_r2_read = mem[rf_r2];
    always @(posedge clk) if (rf_w_en) mem[rf_rd] <= rf_write_data;

    regfile_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_we(c_we),
        .c_rd(c_rd), .c_r1(c_r1), .c_r2(c_r2), .c_wdata(c_wdata),
        .c_rsp_valid(c_rsp_valid), .c_r1_data(c_r1_data), .c_r2_data(c_r2_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
        .rf_rd(rf_rd), .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_write_data(rf_write_data),
        .rf_w_en(rf_w_en), .rf_r_en(rf_r_en), .rf_r1_read(rf_r1_read), .rf_r2_read(rf_r2_read)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rd, r1, r2;
        logic [31:0] wdata, e1, e2;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : ref_rf[a];
    endfunction

    // Called at a negedge; returns at the negedge after the response cycle.
    task automatic do_core(input logic we, input logic [4:0] rd, r1, r2,
                           input logic [31:0] wd, e1, e2, input string tag);
        int unsigned n = 0;
        c_req_valid = 1'b1; c_we = we; c_rd = rd; c_r1 = r1; c_r2 = r2; c_wdata = wd;
        #1;
        while (!c_req_ready && n < 10) begin @(negedge clk); n++; end
        if (!c_req_ready) begin
            chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
            c_req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        c_req_valid = 1'b0;
        chk({tag, "_issue_ren"},   32'(rf_r_en), 32'd1);
        chk({tag, "_issue_wen"},   32'(rf_w_en), 32'(we));
        chk({tag, "_issue_rd"},    32'(rf_rd),   32'(rd));
        chk({tag, "_issue_r1"},    32'(rf_r1),   32'(r1));
        chk({tag, "_issue_r2"},    32'(rf_r2),   32'(r2));
        chk({tag, "_issue_wdata"}, rf_write_data, wd);
        chk({tag, "_issue_rsp"},   32'(c_rsp_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_rsp_valid"}, 32'(c_rsp_valid), 32'd1);
        chk({tag, "_rsp_r1"},    c_r1_data, e1);
        chk({tag, "_rsp_r2"},    c_r2_data, e2);
        chk({tag, "_rsp_en"},    32'({rf_w_en, rf_r_en}), 32'd0);
        @(negedge clk);
        chk({tag, "_after_rsp"}, 32'(c_rsp_valid), 32'd0);
        chk({tag, "_hold_r1"},   c_r1_data, e1);
        if (we && rd != 5'd0) ref_rf[rd] = wd;
    endtask

    task automatic do_dbg(input logic we, input logic [4:0] a, input logic [31:0] wd,
                          input logic [31:0] e, input string tag);
        int unsigned n = 0;
        d_req_valid = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        #1;
        while (!d_req_ready && n < 10) begin @(negedge clk); n++; end
        if (!d_req_ready) begin
            chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
            d_req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        d_req_valid = 1'b0;
        chk({tag, "_issue_map"}, {17'd0, rf_rd, rf_r1, rf_r2}, {17'd0, a, a, 5'd0});
        chk({tag, "_issue_wen"}, 32'(rf_w_en), 32'(we));
        @(negedge clk);
        chk({tag, "_rsp_valid"}, 32'(d_rsp_valid), 32'd1);
        chk({tag, "_rdata"},     d_rdata, e);
        chk({tag, "_core_rsp"},  32'(c_rsp_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_after_rsp"}, 32'(d_rsp_valid), 32'd0);
        if (we && a != 5'd0) ref_rf[a] = wd;
    endtask

    vec_t vecs[7];

    initial begin
        rst_n = 1'b0; c_req_valid = 1'b1; c_we = 1'b1; c_rd = 5'd3; c_r1 = 5'd3; c_r2 = 5'd3;
        c_wdata = 32'hFFFF_FFFF; d_req_valid = 1'b1; d_we = 1'b1; d_addr = 5'd3; d_wdata = '1;

        // Reset with requests pending: nothing may be accepted or issued.
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", 32'({c_req_ready, d_req_ready}), 32'd0);
            chk("rst_rsp",   32'({c_rsp_valid, d_rsp_valid}), 32'd0);
            chk("rst_en",    32'({rf_w_en, rf_r_en}), 32'd0);
            chk("rst_addr",  {17'd0, rf_rd, rf_r1, rf_r2}, 32'd0);
            chk("rst_wdata", rf_write_data, 32'd0);
        end
        chk("rst_no_write", mem[3], 32'd0);
        c_req_valid = 1'b0; d_req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0] = '{1'b1, 5'd5, 5'd0, 5'd0, 32'hDEAD_BEEF, 32'd0,        32'd0};
        vecs[1] = '{1'b0, 5'd0, 5'd5, 5'd0, 32'd0,         32'hDEAD_BEEF, 32'd0};
        vecs[2] = '{1'b1, 5'd0, 5'd0, 5'd0, 32'h0000_1234, 32'd0,        32'd0};
        vecs[3] = '{1'b0, 5'd0, 5'd0, 5'd5, 32'd0,         32'd0,        32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 5'd7, 5'd0, 5'd0, 32'h0000_0011, 32'd0,        32'd0};
        vecs[5] = '{1'b1, 5'd7, 5'd7, 5'd5, 32'h0000_0055, 32'h0000_0011, 32'hDEAD_BEEF};
        vecs[6] = '{1'b0, 5'd0, 5'd7, 5'd7, 32'd0,         32'h0000_0055, 32'h0000_0055};
        foreach (vecs[i])
            do_core(vecs[i].we, vecs[i].rd, vecs[i].r1, vecs[i].r2, vecs[i].wdata,
                    vecs[i].e1, vecs[i].e2, $sformatf("vec%0d", i));

        // Both sides requesting continuously: grant slots every 3 cycles,
        // with debug taking every 5th slot when the debug port is built in.
        c_req_valid = 1'b1; c_we = 1'b0; c_r1 = 5'd5; c_r2 = 5'd7;
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 5'd7;
        for (int i = 0; i < 30; i++) begin
            int slot, ph;
            bit dslot;
            slot  = i / 3;
            ph    = i % 3;
            dslot = DBG_EN && (slot % 5 == 4);
            #1;
            chk($sformatf("arb_c_ready_%0d", i), 32'(c_req_ready), 32'(ph == 0 && !dslot));
            chk($sformatf("arb_d_ready_%0d", i), 32'(d_req_ready), 32'(ph == 0 && dslot));
            chk($sformatf("arb_c_rsp_%0d", i),   32'(c_rsp_valid), 32'(ph == 2 && !dslot));
            chk($sformatf("arb_d_rsp_%0d", i),   32'(d_rsp_valid), 32'(ph == 2 && dslot));
            if (ph == 2 && !dslot) chk($sformatf("arb_c_data_%0d", i), c_r1_data ^ c_r2_data,
                                       ref_rd(5'd5) ^ ref_rd(5'd7));
            if (ph == 2 && dslot)  chk($sformatf("arb_d_data_%0d", i), d_rdata, ref_rd(5'd7));
            @(negedge clk);
        end
        c_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("d_rdata_idle", d_rdata, DBG_EN ? ref_rd(5'd7) : 32'd0);

        // Reset landing on the edge that ends ISSUE of a write to x9.
        if (DBG_EN) begin
            d_req_valid = 1'b1; d_we = 1'b1; d_addr = 5'd9; d_wdata = 32'h0000_00A5;
            #1; chk("ri_accept", 32'(d_req_ready), 32'd1);
        end else begin
            c_req_valid = 1'b1; c_we = 1'b1; c_rd = 5'd9; c_r1 = 5'd9; c_r2 = 5'd0;
            c_wdata = 32'h0000_00A5;
            #1; chk("ri_accept", 32'(c_req_ready), 32'd1);
        end
        @(negedge clk);
        d_req_valid = 1'b0;
        chk("ri_issue_wen", 32'(rf_w_en), 32'd1);
        rst_n = 1'b0;
        c_req_valid = 1'b1; c_we = 1'b0; c_r1 = 5'd9;
        @(negedge clk);
        chk("ri_no_rsp",   32'({c_rsp_valid, d_rsp_valid}), 32'd0);
        chk("ri_en",       32'({rf_w_en, rf_r_en}), 32'd0);
        chk("ri_ready",    32'({c_req_ready, d_req_ready}), 32'd0);
        chk("ri_out_rst",  c_r1_data | c_r2_data | d_rdata, 32'd0);
        chk("ri_addr_rst", {17'd0, rf_rd, rf_r1, rf_r2}, 32'd0);
        c_req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ri_still_idle", 32'({c_rsp_valid, d_rsp_valid, rf_r_en}), 32'd0);
        ref_rf[9] = 32'h0000_00A5;
        if (DBG_EN) do_dbg(1'b0, 5'd9, 32'd0, 32'h0000_00A5, "ri_dbg_read");
        do_core(1'b0, 5'd0, 5'd9, 5'd0, 32'd0, 32'h0000_00A5, 32'd0, "ri_read");

        // Random traffic against the shadow register file.
        for (int i = 0; i < 40; i++) begin
            logic        we;
            logic [4:0]  rd, r1, r2;
            logic [31:0] wd;
            we = 1'($urandom_range(0, 1));
            rd = 5'($urandom_range(0, 12));
            r1 = 5'($urandom_range(0, 12));
            r2 = 5'($urandom_range(0, 12));
            wd = $urandom;
            if (DBG_EN && ($urandom_range(0, 3) == 0))
                do_dbg(we, rd, wd, ref_rd(rd), $sformatf("rnd_dbg%0d", i));
            else
                do_core(we, rd, r1, r2, wd, ref_rd(r1), ref_rd(r2), $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
